// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop are reused for WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             x;
  logic             y;
  logic             d;
  logic             bo;

  assign x  = a_sr[0];
  assign y  = b_sr[0];
  assign d  = x ^ y ^ borrow;
  assign bo = (~x & y) | (~(x ^ y) & borrow);

  // New bits enter at the MSB so that after WIDTH shifts bit 0 sits at position 0.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign res_next = d;
    end else begin : g_wide
      assign res_next = {d, res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            res    <= '0;
            count  <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bo;
          res    <= res_next;
          count  <= count + CW'(1);
          // diff/bout only move on the completing edge so they hold the last result during RUN.
          if (count == LAST) begin
            diff  <= res_next;
            bout  <= bo;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 1, 4 and 8.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin1 = 1'b0, bin4 = 1'b0, bin8 = 1'b0;
  logic       busy1, busy4, busy8;
  logic       done1, done4, done8;
  logic [0:0] diff1;
  logic [3:0] diff4;
  logic [7:0] diff8;
  logic       bout1, bout4, bout8;

  int         sel = 4;
  logic       busyS, doneS, boutS;
  logic [7:0] diffS;
  logic [7:0] heldDiff;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));

  // Route the DUT currently under test onto common observation signals.
  always_comb begin
    busyS = busy4;
    doneS = done4;
    boutS = bout4;
    diffS = {4'h0, diff4};
    case (sel)
      1: begin busyS = busy1; doneS = done1; boutS = bout1; diffS = {7'h0, diff1}; end
      8: begin busyS = busy8; doneS = done8; boutS = bout8; diffS = diff8; end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                input logic bi, output logic [7:0] ed, output logic eb);
    int m;
    int r;
    m  = (1 << w) - 1;
    r  = (int'(av) & m) - (int'(bv) & m) - int'(bi);
    ed = 8'(r & m);
    eb = (r < 0);
  endfunction

  task automatic dropStarts();
    start1 = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Drives operands and start at a negedge; the caller's next step() is the accepting edge.
  task automatic applyStimulus(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    @(negedge clk);
    sel = w;
    #1;
    heldDiff = diffS;
    case (w)
      1: begin a1 = av[0:0]; b1 = bv[0:0]; bin1 = bi; start1 = 1'b1; end
      8: begin a8 = av;      b8 = bv;      bin8 = bi; start8 = 1'b1; end
      default: begin a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi; start4 = 1'b1; end
    endcase
  endtask

  // Called in the first RUN cycle; returns in the DONE cycle.
  task automatic finishOp(input int w, input logic [7:0] expDiff, input logic expBout, input string tag);
    int   cycles;
    logic moved;
    cycles = 0;
    moved  = 1'b0;
    while (busyS === 1'b1 && cycles < 3 * w + 5) begin
      if (diffS !== heldDiff) moved = 1'b1;
      cycles++;
      step();
    end
    checkOutput({tag, " busy cycles"}, cycles, w);
    checkOutput({tag, " diff held"}, moved, 0);
    checkOutput({tag, " done"}, doneS, 1);
    checkOutput({tag, " diff"}, diffS, expDiff);
    checkOutput({tag, " bout"}, boutS, expBout);
  endtask

  task automatic runOp(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input string tag);
    logic [7:0] ed;
    logic       eb;
    model(w, av, bv, bi, ed, eb);
    applyStimulus(w, av, bv, bi);
    step();
    dropStarts();
    finishOp(w, ed, eb, tag);
  endtask

  initial begin
    int   widths[3] = '{1, 4, 8};
    logic sawDone;
    logic [7:0] av, bv;
    logic bi;

    // Reset state of all three instances
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      sel = widths[i];
      #1;
      checkOutput($sformatf("reset busy w%0d", widths[i]), busyS, 0);
      checkOutput($sformatf("reset done w%0d", widths[i]), doneS, 0);
      checkOutput($sformatf("reset diff w%0d", widths[i]), diffS, 0);
      checkOutput($sformatf("reset bout w%0d", widths[i]), boutS, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed WIDTH=4 cases
    runOp(4, 8'd9, 8'd3, 1'b0, "T1");
    runOp(4, 8'd3, 8'd9, 1'b0, "T2 underflow");
    runOp(4, 8'd0, 8'd0, 1'b1, "T2 borrow-in");

    // start held through RUN with changed operands, then accepted from DONE
    applyStimulus(4, 8'd9, 8'd3, 1'b0);
    step();
    a4 = 4'd5;
    b4 = 4'd5;
    finishOp(4, 8'd6, 1'b0, "T3 ignore");
    heldDiff = diffS;
    step();
    dropStarts();
    checkOutput("T3 b2b busy", busyS, 1);
    finishOp(4, 8'd0, 1'b0, "T3 b2b");

    // Abort mid-RUN
    runOp(4, 8'd9, 8'd3, 1'b0, "T4 pre");
    applyStimulus(4, 8'd7, 8'd2, 1'b0);
    step();
    dropStarts();
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("T4 busy", busyS, 0);
    checkOutput("T4 done", doneS, 0);
    checkOutput("T4 diff", diffS, 0);
    checkOutput("T4 bout", boutS, 0);
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      sawDone |= doneS;
    end
    checkOutput("T4 no done", sawDone, 0);

    // rst and start together: start dropped
    applyStimulus(4, 8'd9, 8'd3, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dropStarts();
    checkOutput("rst+start busy", busyS, 0);
    step();
    checkOutput("rst+start idle", busyS, 0);

    // WIDTH=8 and WIDTH=1 directed
    runOp(8, 8'd200, 8'd55, 1'b0, "T5 200-55");
    runOp(8, 8'd255, 8'd255, 1'b1, "T5 255-255-1");
    runOp(1, 8'd0, 8'd1, 1'b0, "W1 0-1");
    runOp(1, 8'd1, 8'd0, 1'b1, "W1 1-0-1");
    runOp(1, 8'd1, 8'd0, 1'b0, "W1 1-0");

    // Randomized operations per width, with occasional idle gaps
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 1000; n++) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        bi = 1'($urandom);
        runOp(widths[i], av, bv, bi, $sformatf("rand w%0d", widths[i]));
        if ($urandom_range(1, 0) == 1) begin
          step();
          checkOutput($sformatf("rand w%0d done pulse", widths[i]), doneS, 0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
